// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-read-port register file.
// REGFILE_BYPASS_EN (optional) enables write-through forwarding in regfile_mp.
package regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dump_state_t;

    localparam int ZERO_REG = 0;

    // Low bit offset of lane idx in a packed bus of width-bit lanes.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump engine: streams registers 0..DEPTH-1 over a valid/ready handshake.
// Forwarding of Dump_Data under REGFILE_BYPASS_EN happens in the parent's read lane.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no dump active; waits for Dump_Start
//   ST_RUN  | beat valid at r_cnt; advances on Dump_Ready
//   ST_DONE | last beat accepted; Dump_Done high for this one cycle
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Dump_Start,
    input  logic              Dump_Ready,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              Dump_Valid,
    output logic [ADDR_W-1:0] Dump_Addr,
    output logic [DATA_W-1:0] Dump_Data,
    output logic              Dump_Busy,
    output logic              Dump_Done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    dump_state_t       r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Dump_Start) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (Dump_Ready) begin
                        if (r_cnt == LAST_IDX) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd_addr  = r_cnt;
    assign Dump_Valid = r_valid;
    assign Dump_Addr  = r_cnt;
    // Data is live from the array, so a write during a stall changes the beat.
    assign Dump_Data  = r_valid ? i_rd_data : '0;
    assign Dump_Busy  = r_busy;
    assign Dump_Done  = r_done;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with N_RD combinational read ports, r0 hardwired to 0,
// and a handshaked dump engine. Define REGFILE_BYPASS_EN for same-cycle write forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int N_RD   = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Reg_Write,
    input  logic [ADDR_W-1:0]      Write_Register,
    input  logic [DATA_W-1:0]      Write_Data,
    input  logic [N_RD*ADDR_W-1:0] Read_Register,
    output logic [N_RD*DATA_W-1:0] Read_Data,
    input  logic                   Dump_Start,
    input  logic                   Dump_Ready,
    output logic                   Dump_Valid,
    output logic [ADDR_W-1:0]      Dump_Addr,
    output logic [DATA_W-1:0]      Dump_Data,
    output logic                   Dump_Busy,
    output logic                   Dump_Done
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_dump_addr;
    logic [DATA_W-1:0] w_dump_data;

    assign w_wr_en = Reg_Write && (Write_Register != ADDR_W'(ZERO_REG));

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[Write_Register] <= Write_Data;
        end
    end

    function automatic logic [DATA_W-1:0] rd_lane(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = (addr == ADDR_W'(ZERO_REG)) ? '0 : r_mem[addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (addr == Write_Register)) begin
            val = Write_Data;
        end
`endif
        return val;
    endfunction

    for (genvar g = 0; g < N_RD; g++) begin : g_rd
        localparam int LO_A = slice_lo(g, ADDR_W);
        localparam int LO_D = slice_lo(g, DATA_W);
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = Read_Register[LO_A +: ADDR_W];
        always_comb begin
            w_data = rd_lane(w_addr);
        end
        assign Read_Data[LO_D +: DATA_W] = w_data;
    end

    always_comb begin
        w_dump_data = rd_lane(w_dump_addr);
    end

    regfile_dump_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dump_ctrl (
        .Clock      (Clock),
        .Reset      (Reset),
        .Dump_Start (Dump_Start),
        .Dump_Ready (Dump_Ready),
        .i_rd_data  (w_dump_data),
        .o_rd_addr  (w_dump_addr),
        .Dump_Valid (Dump_Valid),
        .Dump_Addr  (Dump_Addr),
        .Dump_Data  (Dump_Data),
        .Dump_Busy  (Dump_Busy),
        .Dump_Done  (Dump_Done)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (N_RD=3); expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int NR    = 3;
    localparam int AW    = 5;

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic             Reg_Write;
    logic [AW-1:0]    Write_Register;
    logic [DW-1:0]    Write_Data;
    logic [NR*AW-1:0] Read_Register;
    logic [NR*DW-1:0] Read_Data;
    logic             Dump_Start;
    logic             Dump_Ready;
    logic             Dump_Valid;
    logic [AW-1:0]    Dump_Addr;
    logic [DW-1:0]    Dump_Data;
    logic             Dump_Busy;
    logic             Dump_Done;

    regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .N_RD(NR)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Reg_Write      (Reg_Write),
        .Write_Register (Write_Register),
        .Write_Data     (Write_Data),
        .Read_Register  (Read_Register),
        .Read_Data      (Read_Data),
        .Dump_Start     (Dump_Start),
        .Dump_Ready     (Dump_Ready),
        .Dump_Valid     (Dump_Valid),
        .Dump_Addr      (Dump_Addr),
        .Dump_Data      (Dump_Data),
        .Dump_Busy      (Dump_Busy),
        .Dump_Done      (Dump_Done)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    int            n_pass  = 0;
    int            n_total = 0;
    logic [DW-1:0] model [DEPTH];
    beat_t         sb [$];

    task automatic write_reg(input int a, input logic [DW-1:0] d);
        Reg_Write      = 1'b1;
        Write_Register = AW'(a);
        Write_Data     = d;
        @(negedge Clock);
        Reg_Write = 1'b0;
        if (a != 0) model[a] = d;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic test_reset();
        Read_Register = {AW'(3), AW'(2), AW'(1)};
        #1 Reset = 1'b1;
        #1;
        for (int i = 0; i < NR; i++) begin
            n_total++;
            if (Read_Data[i*DW +: DW] !== '0) $display("FAIL reset_read%0d: got %h required 0", i, Read_Data[i*DW +: DW]);
            else n_pass++;
        end
        n_total++;
        if ({Dump_Valid, Dump_Busy, Dump_Done, Dump_Addr, Dump_Data} !== '0)
            $display("FAIL reset_dump_outs: got v%b b%b d%b a%h data%h required all 0", Dump_Valid, Dump_Busy, Dump_Done, Dump_Addr, Dump_Data);
        else n_pass++;
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        write_reg(1, 32'h0000_1111);
        write_reg(2, 32'h0000_2222);
        write_reg(3, 32'h0000_3333);
        n_total++;
        if (Read_Data[DW +: DW] !== 32'h0000_2222) $display("FAIL pre_reset_read1: got %h required 00002222", Read_Data[DW +: DW]);
        else n_pass++;
        Reset = 1'b1;
        #1;
        for (int i = 0; i < NR; i++) begin
            n_total++;
            if (Read_Data[i*DW +: DW] !== '0) $display("FAIL midrun_reset_read%0d: got %h required 0", i, Read_Data[i*DW +: DW]);
            else n_pass++;
        end
        @(negedge Clock);
        Reset = 1'b0;
        clear_model();
        @(negedge Clock);
        #1;
        for (int i = 0; i < NR; i++) begin
            n_total++;
            if (Read_Data[i*DW +: DW] !== '0) $display("FAIL post_reset_read%0d: got %h required 0", i, Read_Data[i*DW +: DW]);
            else n_pass++;
        end
    endtask

    task automatic test_zero_reg();
        @(negedge Clock);
        write_reg(0, 32'hDEAD_BEEF);
        Read_Register = '0;
        #1;
        n_total++;
        if (Read_Data[0 +: DW] !== '0) $display("FAIL zero_reg: got %h required 0", Read_Data[0 +: DW]);
        else n_pass++;
    endtask

    task automatic test_write_read();
        logic [DW-1:0] exp_d [NR];
        exp_d[0] = 32'h1234_5678;
        exp_d[1] = 32'hFFFF_FFFF;
        exp_d[2] = 32'h0000_0000;
        @(negedge Clock);
        write_reg(5, 32'h1234_5678);
        write_reg(31, 32'hFFFF_FFFF);
        Read_Register = {AW'(0), AW'(31), AW'(5)};
        #1;
        for (int i = 0; i < NR; i++) begin
            n_total++;
            if (Read_Data[i*DW +: DW] !== exp_d[i]) $display("FAIL write_read%0d: got %h required %h", i, Read_Data[i*DW +: DW], exp_d[i]);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp_now;
        @(negedge Clock);
        write_reg(7, 32'h1111_1111);
`ifdef REGFILE_BYPASS_EN
        exp_now = 32'hA5A5_A5A5;
`else
        exp_now = 32'h1111_1111;
`endif
        Reg_Write      = 1'b1;
        Write_Register = AW'(7);
        Write_Data     = 32'hA5A5_A5A5;
        Read_Register  = {AW'(0), AW'(5), AW'(7)};
        #1;
        n_total++;
        if (Read_Data[0 +: DW] !== exp_now) $display("FAIL bypass_same_cycle: got %h required %h", Read_Data[0 +: DW], exp_now);
        else n_pass++;
        n_total++;
        if (Read_Data[DW +: DW] !== 32'h1234_5678) $display("FAIL bypass_other_port: got %h required 12345678", Read_Data[DW +: DW]);
        else n_pass++;
        @(negedge Clock);
        Reg_Write = 1'b0;
        model[7]  = 32'hA5A5_A5A5;
        #1;
        n_total++;
        if (Read_Data[0 +: DW] !== 32'hA5A5_A5A5) $display("FAIL bypass_next_cycle: got %h required a5a5a5a5", Read_Data[0 +: DW]);
        else n_pass++;
    endtask

    // restart_beat >= 0 re-pulses Dump_Start at that beat; reset_beat >= 0 resets at that beat.
    task automatic test_dump(input int restart_beat, input int reset_beat);
        int            beats = 0;
        int            dones = 0;
        int            cyc = 0;
        int            post = 0;
        bit            stalled = 0;
        bit            restarted = 0;
        bit            was_reset = 0;
        bit            saw_bad = 0;
        bit            rdy = 0;
        logic [AW-1:0] held = '0;
        beat_t         e;
        @(negedge Clock);
        for (int i = 0; i < DEPTH; i++) begin
            e.addr = AW'(i);
            e.data = model[i];
            sb.push_back(e);
        end
        Dump_Start = 1'b1;
        @(negedge Clock);
        while (1) begin
            if (Dump_Done) dones++;
            if (dones > 0) post++;
            if (post >= 3) break;
            if (cyc >= 200) begin
                n_total++;
                $display("FAIL dump_timeout: beats %0d dones %0d required 32 beats and one done", beats, dones);
                break;
            end
            if (reset_beat >= 0 && beats == reset_beat) begin
                Dump_Start = 1'b0;
                Dump_Ready = 1'b0;
                Reset      = 1'b1;
                #1;
                n_total++;
                if ({Dump_Valid, Dump_Busy, Dump_Done, Dump_Addr, Dump_Data} !== '0)
                    $display("FAIL reset_mid_dump: got v%b b%b d%b a%h required all 0", Dump_Valid, Dump_Busy, Dump_Done, Dump_Addr);
                else n_pass++;
                #2 Reset = 1'b0;
                clear_model();
                sb.delete();
                was_reset = 1;
                repeat (6) begin
                    @(negedge Clock);
                    if (Dump_Done || Dump_Valid || Dump_Busy) saw_bad = 1;
                end
                n_total++;
                if (saw_bad) $display("FAIL reset_no_done: got activity after reset required none");
                else n_pass++;
                break;
            end
            if (stalled && Dump_Valid) begin
                n_total++;
                if (Dump_Addr !== held) $display("FAIL dump_addr_hold: got %0d required %0d", Dump_Addr, held);
                else n_pass++;
            end
            rdy        = ~rdy;
            Dump_Ready = rdy;
            Dump_Start = (restart_beat >= 0 && beats == restart_beat && !restarted);
            if (Dump_Start) restarted = 1;
            if (Dump_Valid && rdy) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL dump_extra_beat: got addr %0d required no beat", Dump_Addr);
                end else begin
                    e = sb.pop_front();
                    if (Dump_Addr !== e.addr || Dump_Data !== e.data)
                        $display("FAIL dump_beat: got addr %0d data %h required addr %0d data %h", Dump_Addr, Dump_Data, e.addr, e.data);
                    else n_pass++;
                end
                beats++;
                stalled = 0;
            end else if (Dump_Valid) begin
                stalled = 1;
                held    = Dump_Addr;
            end
            @(negedge Clock);
            cyc++;
        end
        Dump_Start = 1'b0;
        Dump_Ready = 1'b0;
        if (!was_reset) begin
            n_total++;
            if (beats != DEPTH || dones != 1 || sb.size() != 0 || Dump_Busy !== 1'b0)
                $display("FAIL dump_totals: got beats %0d dones %0d left %0d busy %b required 32 1 0 0", beats, dones, sb.size(), Dump_Busy);
            else n_pass++;
        end
    endtask

    initial begin
        Reg_Write      = 1'b0;
        Write_Register = '0;
        Write_Data     = '0;
        Read_Register  = '0;
        Dump_Start     = 1'b0;
        Dump_Ready     = 1'b0;
        clear_model();
        test_reset();
        test_zero_reg();
        test_write_read();
        test_bypass();
        @(negedge Clock);
        for (int i = 1; i < DEPTH; i++) write_reg(i, DW'(i * 3));
        test_dump(-1, -1);
        test_dump(10, -1);
        test_dump(-1, 15);
        test_dump(-1, -1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; successor to the single-pair 32x32 register file in the datapath.
- Width, depth and read-port count are configurable; register 0 is hardwired to zero; asynchronous reset clears state.
- Includes a handshaked dump engine that streams every register, one per accepted beat, to a debug/monitor sink. This replaces ad-hoc periodic printing.

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers; power of two, >= 2
- N_RD, 2, number of combinational read ports
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; clears all registers and the dump FSM
- Reg_Write  in  1  write enable, sampled on posedge Clock
- Write_Register  in  ADDR_W  write address
- Write_Data  in  DATA_W  write data
- Read_Register  in  N_RD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W]
- Read_Data  out  N_RD*DATA_W  packed read data; port i is bits [i*DATA_W +: DATA_W]
- Dump_Start  in  1  request a full dump; single-cycle pulse
- Dump_Ready  in  1  sink accepts the current beat
- Dump_Valid  out  1  dump beat valid
- Dump_Addr  out  ADDR_W  register index of the current beat
- Dump_Data  out  DATA_W  register value of the current beat
- Dump_Busy  out  1  dump in progress
- Dump_Done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (async, active-high):
  - all registers = 0; FSM = IDLE.
  - Dump_Valid = 0, Dump_Busy = 0, Dump_Done = 0, Dump_Addr = 0, Dump_Data = 0.
- Write path:
  - On posedge Clock, if Reg_Write=1 and Write_Register != 0, the register takes Write_Data.
  - Writes to address 0 are dropped.
- Read path:
  - Combinational, zero latency.
  - Read_Data[i] = reg[Read_Register[i]]; address 0 always returns 0.
  - Without bypass, a same-cycle write is visible on reads only after the edge.
- Dump FSM states:
  - IDLE -> RUN when Dump_Start=1; the index counter loads 0.
  - RUN: Dump_Valid=1, Dump_Addr=counter, Dump_Data=reg[counter] (live value, combinational from the array).
  - In RUN, Dump_Valid=1 and Dump_Ready=1 is an accepted beat. If counter < DEPTH-1, counter increments. If counter == DEPTH-1, go to DONE.
  - DONE: Dump_Done=1 for exactly one cycle, Dump_Valid=0, then IDLE.
  - Dump_Busy=1 in RUN and DONE.
- Dump handshake rules:
  - While Dump_Valid=1 and Dump_Ready=0, Dump_Addr holds. Dump_Data follows the live register, so a write to that address while stalled changes the beat.
  - Dump_Start while Dump_Busy=1 is ignored; no restart, no queueing.
  - Dump_Start and Reg_Write in the same cycle are independent; both take effect.
  - The counter does not wrap: exactly DEPTH beats per dump, addresses 0..DEPTH-1 in order.
- Reset mid-dump: the FSM returns to IDLE immediately, no Dump_Done is produced, and the registers are cleared.
- Width rules: no arithmetic on data. The counter is ADDR_W bits, with the terminal compare at DEPTH-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If Reg_Write=1, Write_Register != 0 and Read_Register[i] == Write_Register, then Read_Data[i] = Write_Data in the same cycle. Dump_Data is forwarded under the same rule.
- Not defined: reads return the stored value only, and the new value appears the cycle after the edge.

Decomposition:
- Shared package regfile_pkg holds:
  - the dump FSM state typedef (IDLE, RUN, DONE);
  - the localparam ZERO_REG = 0;
  - a helper function for packed-port slicing.
- One sub-module is natural: regfile_dump_ctrl, containing the FSM, counter and handshake outputs. It drives an address to the array and receives the read data back.
- The storage array and read muxes stay in regfile_mp.

Test Plan:
- Reset/zero register:
  - Assert Reset mid-run; all Read_Data = 0 while Reset is high and after it deasserts.
  - Write 0xDEADBEEF to r0; read r0 -> 0.
- Write/read, N_RD=3:
  - Write r5=0x12345678 and r31=0xFFFFFFFF.
  - Read ports {5,31,0} -> {0x12345678, 0xFFFFFFFF, 0}.
- Bypass:
  - Same cycle: Reg_Write=1, r7<=0xA5A5A5A5, Read_Register[0]=7.
  - With REGFILE_BYPASS_EN: reads 0xA5A5A5A5 that cycle. Without it: reads the old value that cycle, 0xA5A5A5A5 next cycle.
- Dump with backpressure:
  - Preload r1..r31 = index*3; pulse Dump_Start; toggle Dump_Ready 1/0 every cycle.
  - Expect 32 accepted beats with addr 0..31 and data 0,3,..,93; addr holds during stalls; Dump_Done pulses once.
- Dump_Start while busy:
  - Re-pulse Dump_Start at beat 10 -> ignored; the sequence continues to 31 with a single Dump_Done.
- Reset mid-dump:
  - Assert Reset at beat 15 -> Dump_Valid/Dump_Busy drop immediately and no Dump_Done.
  - A following Dump_Start streams all zeros for addresses 0..31.
